wb_arbiter_2m: RTL
==================

# wb_arbiter_2m

Two-master Wishbone B4 classic arbiter sharing one slave port between the data-memory master (M0) and the instruction-fetch master (M1). The block sits between the pipeline's memory masters and the memory/peripheral interconnect. It grants the bus per whole cycle (CYC framing) and uses fair alternation when both masters contend. Routing is combinational; only the grant is registered.

## Interface

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  M0 (data master) cycle/strobe/write
- m0_adr_i  in  ADDR_WIDTH  M0 address
- m0_dat_i  in  DATA_WIDTH  M0 write data
- m0_sel_i  in  DATA_WIDTH/8  M0 byte select
- m0_ack_o  out  1  M0 acknowledge
- m0_dat_o  out  DATA_WIDTH  M0 read data
- m1_* (cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, ack_o, dat_o)  same as M0; M1 is the instruction-fetch master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_WIDTH/8  slave byte select
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  DATA_WIDTH  slave read data
- grant  out  2  one-hot current owner (01=M0, 10=M1, 00=none), for debug/perf counters

## Operation

- Registers: state in {IDLE, GNT_M0, GNT_M1}; last (1 bit, last granted master, 0=M0, 1=M1).
- Reset (reset=1 at edge): state=IDLE, last=1 (M0 wins first contention).
- Arbitration evaluated at every edge where state=IDLE, or where the owner's cyc_i=0 (release):
  - only M0 cyc_i=1 -> GNT_M0; only M1 cyc_i=1 -> GNT_M1
  - both -> grant master != last
  - neither -> IDLE
  - on any grant, last <= granted index
- While in GNT_Mx with mx_cyc_i=1, state holds regardless of other requests; no preemption. Multiple STB/ACK beats inside one CYC are allowed.
- Slave outputs in GNT_Mx: s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i, and we/adr/dat/sel copied from Mx, all combinational.
- Slave outputs in IDLE: all s_* outputs = 0.
- ACK routing: mx_ack_o = s_ack_i & (state==GNT_Mx) & mx_cyc_i; the non-owner's ack_o is always 0.
- Read data: m0_dat_o = m1_dat_o = s_dat_i, broadcast. Valid only with the respective ack.
- grant = one-hot of state; 00 in IDLE.
- s_ack_i while IDLE is ignored and not forwarded.

## Timing

- Grant latency: a request (cyc_i rising) seen in IDLE at edge N makes s_cyc_o/s_stb_o high after edge N. The slave therefore sees the request one cycle after the master raises it.
- Handover: when the owner drops cyc_i and the other master is requesting, the grant switches at that same edge. There is no idle cycle between owners.
- ACK is passed through in the same cycle it arrives; there is no added read latency.
- A master that raises cyc_i while not owning the bus sees ack_o=0 until granted. Its stb must stay high, per Wishbone, until acked.
- Reset mid-cycle: state goes to IDLE at that edge, all s_* outputs are 0 and both ack_o are 0 the following cycle. Any in-flight slave ack is dropped.
- Owner holding cyc_i indefinitely starves the other master; this is by design, because masters drop cyc after each ack.

## Test plan

- M1 alone: m1_cyc/stb=1, adr=0x8000_0000 -> s_cyc/stb high next cycle with s_adr_o=0x8000_0000, grant=10. Slave acks with 0x00000013 -> m1_ack_o=1 and m1_dat_o=0x00000013 in the same cycle, m0_ack_o=0.
- Simultaneous first contention after reset: both cyc raised together -> M0 granted first. After M0 drops cyc, grant switches to M1 at that edge with no IDLE cycle; s_adr_o follows M1.
- Fairness: M0 requests continuously (re-raises cyc immediately) while M1 holds a request -> grants alternate M0, M1, M0, M1 over 4 transactions.
- No preemption: M1 owns the bus with the slave stalling ack 5 cycles while M0 requests -> grant stays 10 for all 5 cycles, m0_ack_o stays 0, and M0 is granted after M1 releases.
- Write path: M0 write with we=1, sel=0011, dat=0xDEADBEEF -> s_we_o=1, s_sel_o=0011, s_dat_o=0xDEADBEEF while granted, and all s_* = 0 after release with no requests pending.
- Reset mid-transaction: reset asserted while GNT_M1 with stb high -> next cycle grant=00, s_cyc_o=0, a stray s_ack_i=1 gives m1_ack_o=0, and the first contention after reset goes to M0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 classic arbiter: grants the single slave port per whole
// CYC, alternating fairly between M0 (data) and M1 (instruction fetch) on contention.
module wb_arbiter_2m #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_we_i,
   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
   output logic                    m0_ack_o,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_we_i,
   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
   output logic                    m1_ack_o,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   output logic [DATA_WIDTH/8-1:0] s_sel_o,
   input  logic                    s_ack_i,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   output logic [1:0]              grant
);

   // One-hot state encoding so the grant vector is the state register itself.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GNT_M0 = 2'b01,
      GNT_M1 = 2'b10
   } state_t;

   state_t state_r;
   state_t state_nxt_s;
   logic   last_r;
   logic   last_nxt_s;
   logic   rearb_s;

   // Grant state and last-granted master registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         last_r  <= last_nxt_s;
      end
   end

   // Arbitration: only re-decided when idle or when the current owner drops CYC.
   always_comb begin
      state_nxt_s = state_r;
      last_nxt_s  = last_r;
      case (state_r)
         IDLE:    rearb_s = 1'b1;
         GNT_M0:  rearb_s = ~m0_cyc_i;
         GNT_M1:  rearb_s = ~m1_cyc_i;
         default: rearb_s = 1'b1;
      endcase
      if (rearb_s) begin
         if (m0_cyc_i && m1_cyc_i) begin
            if (last_r) begin
               state_nxt_s = GNT_M0;
               last_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = GNT_M1;
               last_nxt_s  = 1'b1;
            end
         end else if (m0_cyc_i) begin
            state_nxt_s = GNT_M0;
            last_nxt_s  = 1'b0;
         end else if (m1_cyc_i) begin
            state_nxt_s = GNT_M1;
            last_nxt_s  = 1'b1;
         end else begin
            state_nxt_s = IDLE;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Combinational routing of the owner's signals to the slave and of ACK back.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      case (state_r)
         GNT_M0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            m0_ack_o = s_ack_i & m0_cyc_i;
         end
         GNT_M1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            m1_ack_o = s_ack_i & m1_cyc_i;
         end
         default: begin
            s_cyc_o  = 1'b0;
            m0_ack_o = 1'b0;
         end
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign grant    = state_r;

endmodule
